// File: rtl/aes_eim_pkg.sv
// rtl/aes_eim_pkg.sv - register offsets, STATUS bits and FSM encoding for the AES EIM window
package aes_eim_pkg;

  localparam logic [5:0] OFF_KEY       = 6'h00;
  localparam logic [5:0] OFF_TEXT_IN   = 6'h08;
  localparam logic [5:0] OFF_TEXT_OUT  = 6'h10;
  localparam logic [5:0] OFF_CTRL      = 6'h18;
  localparam logic [5:0] OFF_STATUS    = 6'h19;
  localparam logic [5:0] OFF_BLKCNT    = 6'h1A;
  localparam logic [5:0] OFF_AUTOSTART = 6'h0F;

  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_VALID_BIT = 1;
  localparam int STATUS_ERR_BIT   = 2;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_LOAD = 2'd1,
    FSM_BUSY = 2'd2
  } fsm_state_t;

  // Word 0 is the most significant halfword of a 128-bit block.
  function automatic int word_lsb(input logic [2:0] n);
    return (7 - int'(n)) * 16;
  endfunction

endpackage

// File: rtl/aes_eim_ctrl.sv
// rtl/aes_eim_ctrl.sv - cipher handshake FSM (IDLE/LOAD/BUSY) and completed-block counter
module aes_eim_ctrl
  import aes_eim_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        aes_done,
  output logic        aes_ld,
  output logic        busy,
  output logic        capture,
  output logic [15:0] blkcnt
);

  fsm_state_t state_q;
  fsm_state_t state_d;
  logic [15:0] blkcnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FSM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FSM_IDLE: if (start) state_d = FSM_LOAD;
      FSM_LOAD: state_d = FSM_BUSY;
      FSM_BUSY: if (aes_done) state_d = FSM_IDLE;
      default:  state_d = FSM_IDLE;
    endcase
  end

  // aes_done only matters in BUSY; stray pulses elsewhere are ignored.
  always_comb begin
    aes_ld  = 1'b0;
    busy    = 1'b0;
    capture = 1'b0;
    case (state_q)
      FSM_LOAD: begin
        aes_ld = 1'b1;
        busy   = 1'b1;
      end
      FSM_BUSY: begin
        busy    = 1'b1;
        capture = aes_done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blkcnt_q <= 16'h0000;
    end else if (capture) begin
      blkcnt_q <= blkcnt_q + 16'd1;
    end
  end

  assign blkcnt = blkcnt_q;

endmodule

// File: rtl/aes_eim_regs.sv
// rtl/aes_eim_regs.sv - EIM register window around an AES core; AES_EIM_AUTOSTART_EN starts on TEXT_IN word 7 writes
module aes_eim_regs
  import aes_eim_pkg::*;
#(
  parameter logic [15:0]  BASE_ADDR = 16'h0000,
  parameter logic [127:0] KEY_RST   = 128'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [15:0]  addr,
  input  logic [15:0]  eim_in,
  output logic [15:0]  eim_out,
  output logic         aes_ld,
  output logic [127:0] aes_key,
  output logic [127:0] aes_text_in,
  input  logic         aes_done,
  input  logic [127:0] aes_text_out
);

  logic         hit;
  logic [5:0]   off;
  logic [2:0]   widx;
  logic         busy;
  logic         capture;
  logic [15:0]  blkcnt;
  logic         key_wr;
  logic         text_wr;
  logic         ctrl_wr;
  logic         auto_wr;
  logic         clear;
  logic         start;
  logic         blocked_wr;
  logic [127:0] key_q;
  logic [127:0] text_in_q;
  logic [127:0] text_out_q;
  logic         err_q;
  logic         valid_q;
  logic [15:0]  status;
  logic [15:0]  rd_data;

  assign hit  = (addr[15:6] == BASE_ADDR[15:6]);
  assign off  = addr[5:0];
  assign widx = off[2:0];

  assign key_wr  = wr && hit && !busy && (off[5:3] == OFF_KEY[5:3]);
  assign text_wr = wr && hit && !busy && (off[5:3] == OFF_TEXT_IN[5:3]);
  assign ctrl_wr = wr && hit && (off == OFF_CTRL);
  assign clear   = ctrl_wr && eim_in[CTRL_CLEAR_BIT];

`ifdef AES_EIM_AUTOSTART_EN
  assign auto_wr = text_wr && (off == OFF_AUTOSTART);
`else
  assign auto_wr = 1'b0;
`endif

  assign start = !busy && ((ctrl_wr && eim_in[CTRL_START_BIT]) || auto_wr);

  // Key/plaintext writes and start requests while a block is in flight are dropped and flagged.
  assign blocked_wr = wr && hit && busy &&
                      ((off[5:4] == 2'b00) || (ctrl_wr && eim_in[CTRL_START_BIT]));

  aes_eim_ctrl u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .aes_done (aes_done),
    .aes_ld   (aes_ld),
    .busy     (busy),
    .capture  (capture),
    .blkcnt   (blkcnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q      <= KEY_RST;
      text_in_q  <= 128'h0;
      text_out_q <= 128'h0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      eim_out    <= 16'h0000;
    end else begin
      if (key_wr)  key_q[word_lsb(widx) +: 16]     <= eim_in;
      if (text_wr) text_in_q[word_lsb(widx) +: 16] <= eim_in;
      if (capture) text_out_q <= aes_text_out;
      if (blocked_wr)  err_q <= 1'b1;
      else if (clear)  err_q <= 1'b0;
      if (capture)              valid_q <= 1'b1;
      else if (start || clear)  valid_q <= 1'b0;
      eim_out <= rd_data;
    end
  end

  always_comb begin
    status                   = 16'h0000;
    status[STATUS_BUSY_BIT]  = busy;
    status[STATUS_VALID_BIT] = valid_q;
    status[STATUS_ERR_BIT]   = err_q;
  end

  always_comb begin
    rd_data = 16'h0000;
    if (hit) begin
      case (off[5:3])
        3'd0: rd_data = key_q[word_lsb(widx) +: 16];
        3'd1: rd_data = text_in_q[word_lsb(widx) +: 16];
        3'd2: rd_data = text_out_q[word_lsb(widx) +: 16];
        3'd3: begin
          if (off == OFF_STATUS)      rd_data = status;
          else if (off == OFF_BLKCNT) rd_data = blkcnt;
        end
        default: rd_data = 16'h0000;
      endcase
    end
  end

  assign aes_key     = key_q;
  assign aes_text_in = text_in_q;

endmodule

// File: tb/tb_aes_eim_regs.sv
// tb/tb_aes_eim_regs.sv - directed bench for aes_eim_regs; AES_EIM_AUTOSTART_EN selects the autostart checks
module tb_aes_eim_regs;
  import aes_eim_pkg::*;

  localparam logic [15:0]  BASE = 16'h1240;
  localparam logic [127:0] KRST = 128'hcafe_0001_0203_0405_0607_0809_0a0b_beef;
  localparam logic [127:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FPT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr = 1'b0;
  logic [15:0]  addr = 16'h0000;
  logic [15:0]  eim_in = 16'h0000;
  logic [15:0]  eim_out;
  logic         aes_ld;
  logic [127:0] aes_key;
  logic [127:0] aes_text_in;
  logic         aes_done = 1'b0;
  logic [127:0] aes_text_out = 128'h0;

  int checks = 0;
  int errors = 0;
  logic [15:0]  w;
  logic [127:0] v;

  aes_eim_regs #(.BASE_ADDR(BASE), .KEY_RST(KRST)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr),
    .addr         (addr),
    .eim_in       (eim_in),
    .eim_out      (eim_out),
    .aes_ld       (aes_ld),
    .aes_key      (aes_key),
    .aes_text_in  (aes_text_in),
    .aes_done     (aes_done),
    .aes_text_out (aes_text_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [5:0] off, input logic [15:0] data);
    addr = BASE + {10'b0, off};
    eim_in = data;
    wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic read(input logic [5:0] off, output logic [15:0] data);
    addr = BASE + {10'b0, off};
    wr = 1'b0;
    tick();
    data = eim_out;
  endtask

  task automatic write128(input logic [5:0] off, input logic [127:0] val);
    for (int i = 0; i < 8; i++) write(off + 6'(i), val[(7 - i) * 16 +: 16]);
  endtask

  task automatic read128(input logic [5:0] off, output logic [127:0] val);
    logic [15:0] t;
    for (int i = 0; i < 8; i++) begin
      read(off + 6'(i), t);
      val[(7 - i) * 16 +: 16] = t;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tick();
    do_reset();
    chk("rst_aes_ld", aes_ld, 0);
    chk("rst_eim_out", eim_out, 0);
    chk("rst_key", aes_key, KRST);
    chk("rst_text_in", aes_text_in, 0);
    read(OFF_STATUS, w);   chk("rst_status", w, 16'h0000);
    read(OFF_BLKCNT, w);   chk("rst_blkcnt", w, 16'h0000);
    read(OFF_TEXT_OUT, w); chk("rst_text_out0", w, 16'h0000);
    read(OFF_KEY, w);      chk("rst_key_rd0", w, 16'hcafe);

    // read latency: eim_out follows the previous cycle's address
    addr = BASE + 16'h0000;
    tick();
    addr = BASE + 16'h003F;
    chk("lat_hold", eim_out, 16'hcafe);
    tick();
    chk("miss_3f", eim_out, 16'h0000);
    addr = BASE + 16'h0040;
    tick();
    chk("miss_window", eim_out, 16'h0000);
    read(6'h1B, w);     chk("unmapped_1b", w, 16'h0000);
    read(OFF_CTRL, w);  chk("ctrl_reads_0", w, 16'h0000);

    // FIPS-197 vector
    write128(OFF_KEY, FKEY);
    write128(OFF_TEXT_IN, FPT);
    chk("fips_key_port", aes_key, FKEY);
    chk("fips_pt_port", aes_text_in, FPT);
    read128(OFF_KEY, v);     chk("fips_key_rd", v, FKEY);
    read128(OFF_TEXT_IN, v); chk("fips_pt_rd", v, FPT);
    write(OFF_CTRL, 16'h0001);
    chk("fips_ld_pulse", aes_ld, 1);
    read(OFF_STATUS, w);
    chk("fips_ld_one_cycle", aes_ld, 0);
    chk("load_status", w, 16'h0001);

    write(OFF_KEY, 16'hDEAD);
    chk("busy_key_kept", aes_key, FKEY);
    read(OFF_STATUS, w);     chk("busy_err_status", w, 16'h0005);
    read(OFF_TEXT_OUT, w);   chk("busy_old_text_out", w, 16'h0000);
    write(OFF_CTRL, 16'h0002);
    read(OFF_STATUS, w);     chk("busy_cleared", w, 16'h0001);
    read(OFF_STATUS, w);     chk("busy_hold", w, 16'h0001);

    aes_text_out = FCT;
    aes_done = 1'b1;
    tick();
    aes_done = 1'b0;
    aes_text_out = 128'h0;
    read128(OFF_TEXT_OUT, v); chk("fips_ct", v, FCT);
    read(OFF_STATUS, w);      chk("fips_status", w, 16'h0002);
    read(OFF_BLKCNT, w);      chk("fips_blkcnt", w, 16'h0001);
    chk("fips_key_after", aes_key, FKEY);

    // aes_done outside BUSY is ignored
    aes_text_out = {8{16'h1111}};
    aes_done = 1'b1;
    tick();
    aes_done = 1'b0;
    read(OFF_TEXT_OUT, w);  chk("idle_done_ct", w, 16'h69c4);
    read(OFF_BLKCNT, w);    chk("idle_done_cnt", w, 16'h0001);

    // clear plus start in IDLE
    write(OFF_CTRL, 16'h0003);
    chk("ctrl3_ld", aes_ld, 1);
    read(OFF_STATUS, w);    chk("ctrl3_status", w, 16'h0001);
    aes_text_out = {8{16'h2222}};
    aes_done = 1'b1;
    tick();
    aes_done = 1'b0;
    read(OFF_TEXT_OUT + 6'd7, w); chk("ctrl3_ct7", w, 16'h2222);
    read(OFF_BLKCNT, w);          chk("ctrl3_cnt", w, 16'h0002);

    // reset while BUSY abandons the block
    write(OFF_CTRL, 16'h0001);
    tick();
    do_reset();
    chk("rstbusy_eim_out", eim_out, 0);
    aes_text_out = {8{16'h3333}};
    aes_done = 1'b1;
    tick();
    aes_done = 1'b0;
    chk("rstbusy_ld", aes_ld, 0);
    read(OFF_TEXT_OUT, w);  chk("rstbusy_ct", w, 16'h0000);
    read(OFF_BLKCNT, w);    chk("rstbusy_cnt", w, 16'h0000);
    read(OFF_STATUS, w);    chk("rstbusy_status", w, 16'h0000);
    chk("rstbusy_key", aes_key, KRST);

    // TEXT_IN word 7 write: autostart only when enabled
    write(OFF_AUTOSTART, 16'h5a5a);
    chk("w7_data", aes_text_in[15:0], 16'h5a5a);
`ifdef AES_EIM_AUTOSTART_EN
    chk("autostart_ld", aes_ld, 1);
    tick();
    aes_done = 1'b1;
    tick();
    aes_done = 1'b0;
    read(OFF_BLKCNT, w);    chk("autostart_cnt", w, 16'h0001);
`else
    chk("no_autostart_ld", aes_ld, 0);
    read(OFF_STATUS, w);    chk("no_autostart_status", w, 16'h0000);
`endif

    // counter wrap: three cycles per block with inputs held
    do_reset();
    addr = BASE + {10'b0, OFF_CTRL};
    eim_in = 16'h0001;
    wr = 1'b1;
    aes_done = 1'b1;
    repeat (3 * 65535) @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
    aes_done = 1'b0;
    read(OFF_BLKCNT, w);    chk("wrap_ffff", w, 16'hFFFF);
    write(OFF_CTRL, 16'h0001);
    tick();
    aes_done = 1'b1;
    tick();
    aes_done = 1'b0;
    read(OFF_BLKCNT, w);    chk("wrap_zero", w, 16'h0000);
    read(OFF_STATUS, w);    chk("wrap_status", w, 16'h0006);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_eim_regs.md
AES_EIM_REGS -- requirements
Module: aes_eim_regs

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0000, EIM word-address base of the register window; only bits [15:6] are significant.
REQ-002 SHALL have parameter KEY_RST, default 128'h0, key register value after reset.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port wr, input, 1, EIM write strobe; one write per cycle when high.
REQ-006 SHALL have port addr, input, 16, EIM word address.
REQ-007 SHALL have port eim_in, input, 16, EIM write data.
REQ-008 SHALL have port eim_out, output, 16, EIM read data.
REQ-009 SHALL have port aes_ld, output, 1, load pulse to the AES cipher core.
REQ-010 SHALL have port aes_key, output, 128, key to the core.
REQ-011 SHALL have port aes_text_in, output, 128, plaintext to the core.
REQ-012 SHALL have port aes_done, input, 1, core completion pulse.
REQ-013 SHALL have port aes_text_out, input, 128, core ciphertext, valid while aes_done=1.

Function
REQ-014 SHALL decode a hit when addr[15:6]==BASE_ADDR[15:6]; offset=addr[5:0].
REQ-015 SHALL map offsets: 0x00-0x07 KEY (RW), 0x08-0x0F TEXT_IN (RW), 0x10-0x17 TEXT_OUT (RO), 0x18 CTRL (WO), 0x19 STATUS (RO), 0x1A BLKCNT (RO); word n covers bits [127-16n:112-16n].
REQ-016 SHALL register eim_out: the value for the address presented in cycle N appears in cycle N+1; misses and unmapped offsets read 16'h0000; CTRL reads 0.
REQ-017 SHALL run FSM IDLE -> LOAD -> BUSY -> IDLE: IDLE->LOAD on CTRL write with eim_in[0]=1; LOAD lasts exactly one cycle with aes_ld=1; BUSY holds until aes_done=1, then returns to IDLE.
REQ-018 SHALL capture aes_text_out into TEXT_OUT on the cycle aes_done=1 in BUSY, set STATUS.valid, and increment BLKCNT (16-bit, wraps 0xFFFF->0x0000).
REQ-019 SHALL ignore aes_done in IDLE and LOAD.
REQ-020 SHALL, in LOAD or BUSY, drop writes to KEY, TEXT_IN and CTRL start, and set sticky STATUS.err.
REQ-021 SHALL clear STATUS.valid when entering LOAD.
REQ-022 SHALL, on a CTRL write with eim_in[1]=1, clear err and valid; if eim_in[1:0]=2'b11 in IDLE, perform the clear and also start.
REQ-023 SHALL define STATUS as {13'b0, err, valid, busy}; busy=1 in LOAD and BUSY.
REQ-024 SHALL drive aes_key and aes_text_in directly from the KEY and TEXT_IN registers, stable from LOAD until return to IDLE.
REQ-025 SHALL return the previous ciphertext from TEXT_OUT reads while busy.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set FSM=IDLE, aes_ld=0, eim_out=0, KEY=KEY_RST, TEXT_IN=0, TEXT_OUT=0, BLKCNT=0, err=0, valid=0.
REQ-027 SHALL, on reset in LOAD/BUSY, abandon the operation; a later aes_done SHALL NOT capture or count.

Configuration
REQ-028 SHALL, with AES_EIM_AUTOSTART_EN defined, start (as CTRL bit0) on any accepted write to TEXT_IN word 7 (offset 0x0F) in IDLE; the written data is used in that block.
REQ-029 SHALL, without AES_EIM_AUTOSTART_EN, start only on CTRL writes.

Structure
REQ-030 SHALL place register offsets, STATUS bit positions and FSM state encodings in shared package aes_eim_pkg.
REQ-031 SHALL place the FSM and BLKCNT in one sub-module, aes_eim_ctrl; register storage and read mux stay at top.

Verification
REQ-032 SHALL cover FIPS-197: KEY=000102030405060708090a0b0c0d0e0f, TEXT_IN=00112233445566778899aabbccddeeff, CTRL=1 -> one-cycle aes_ld, TEXT_OUT=69c4e0d86a7b0430d8cdb78070b4c55a, STATUS=0x0002, BLKCNT=1.
REQ-033 SHALL cover busy write: KEY word 0 write of 0xDEAD during BUSY -> key unchanged, STATUS=0x0005; CTRL=2 -> STATUS=0x0001 until done.
REQ-034 SHALL cover read latency and misses: addr=BASE+0x19 in cycle N -> eim_out valid in N+1; addr=BASE+0x3F or outside window -> 0x0000.
REQ-035 SHALL cover reset mid-BUSY: rst for one cycle, then aes_done -> TEXT_OUT=0, BLKCNT=0, STATUS=0x0000, key=KEY_RST.
REQ-036 SHALL cover counter wrap: 65536 completions -> BLKCNT=0x0000; with AES_EIM_AUTOSTART_EN, a write to offset 0x0F -> aes_ld next cycle.
